pipelined_mult_nxn: RTL and testbench
=====================================

Name: pipelined_mult_nxn

Overview:
- Parametrised, pipelined N x N array multiplier, the successor to the fixed-width combinational compressor-tree multipliers in the arithmetic library.
- Three register stages: partial-product generation, column compression to two rows, final carry-propagate add.
- Per-operation signed/unsigned mode; valid/ready handshake on both sides with per-stage backpressure and bubble collapsing.
- Sits between operand-issue logic and the accumulator/datapath consumer.

Parameters:
W, 8, operand width in bits (legal 4..16); product width is 2W
SIGNED_EN, 1, 1 = honour is_signed; 0 = is_signed ignored, always unsigned

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand pair presented
in_ready  output  1  stage 1 can accept this cycle
a  input  W  multiplicand
b  input  W  multiplier
is_signed  input  1  1 = both operands two's-complement, 0 = both unsigned
out_valid  output  1  product p valid
out_ready  input  1  consumer accepts p this cycle
p  output  2W  product
busy  output  1  OR of all three stage valid bits

Behaviour:
- One clock; reset is asynchronous and active-high. On rst: all stage valid bits = 0, out_valid = 0, p = 0, busy = 0, in_ready = 1 once rst deasserts. Data registers are also cleared to 0.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_valid, a, b and is_signed are sampled only on an input transfer.
- Stage k holds valid bit vk, k = 1..3, with v3 = out_valid. Define ready4 = out_ready and readyk = !vk || ready(k+1). in_ready = ready1.
  - A bubble in any stage is filled even while the output is stalled.
  - in_ready is combinational from out_ready.
- Stage k loads from stage k-1 when readyk. Otherwise it holds all contents and vk.
- Stage 1:
  - Registers W partial-product rows pp[i][j] = a[j] & b[i].
  - Signed mode uses Baugh-Wooley: invert pp[i][W-1] for i < W-1 and pp[W-1][j] for j < W-1; keep pp[W-1][W-1]; add constant 1 at column W and at column 2W-1.
  - The mode bit travels with the data.
- Stage 2: reduces every column to at most two bits using 3:2 and 2:2 counters (Wallace/Dadda order, implementer's choice). Registers two 2W-bit rows.
- Stage 3: adds the two rows modulo 2^(2W). The registered result drives p.
- Latency: 3 clk edges from input transfer to out_valid when unstalled. Throughput is 1 per cycle.
- p and out_valid are stable while out_valid && !out_ready.
- Arithmetic:
  - Unsigned: p = a * b exactly; max (2^W-1)^2 fits 2W bits.
  - Signed: p = sext(a) * sext(b) as a 2W-bit two's-complement value. (-2^(W-1))^2 = 2^(2W-2) fits.
- Simultaneous input transfer and output transfer in one cycle with the pipe full: both happen, with no bubble inserted.
- Reset mid-operation: all in-flight results are discarded, with no output transfer of them after reset.
- busy = v1 | v2 | v3.

Test Plan:
- Unsigned basics, W=8, is_signed=0: (255,255) -> p=16'hFE01; (0,173) -> 16'h0000; (1,200) -> 16'h00C8. out_valid exactly 3 edges after each transfer.
- Signed corners, W=8, is_signed=1:
  - (8'h80,8'h80) -> 16'h4000
  - (8'hFF,8'h01) -> 16'hFFFF
  - (8'h7F,8'h80) -> 16'hC080
  - (8'hFF,8'hFF) -> 16'h0001
- Mixed mode back-to-back every cycle: (8'hFF,8'hFF,unsigned), then (8'hFF,8'hFF,signed) -> 16'hFE01 then 16'h0001 on consecutive cycles, showing the mode is tracked per operation.
- Backpressure:
  - Stream 5 ops with out_ready=0 for 6 cycles: in_ready drops after 3 accepted, p holds the first result stable.
  - Then out_ready=1: the remaining results come out in order, one per cycle, none lost or duplicated.
- Bubble collapse: one op, 2 idle cycles, out_ready held low, second op -> both accepted with no in_ready stall; the second sits in stage 2 behind the first.
- Reset mid-flight: rst pulse asynchronously between edges with 3 ops in flight -> out_valid, p and busy go to 0 immediately. No stale output appears. An op issued after reset returns correct p with 3-edge latency.
- Exhaustive/random: W=4 exhaustive over all 256 pairs x 2 modes against a reference model. W=16, SIGNED_EN=0: 10k random ops with random out_ready -> p matches the model and is_signed has no effect.

Source files
------------

// File: rtl/pipelined_mult_nxn.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pipelined_mult_nxn: 3-stage W x W multiplier, signed (Baugh-Wooley) or  |
// | unsigned per operation, valid/ready on both sides.  Revision: 1.0       |
// +------------------------------------------------------------------------+
module pipelined_mult_nxn #(
  parameter int W         = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int PW = 2 * W;

  logic            v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [W*W-1:0]  pp_q, pp_d;
  logic            sgn1_q, sgn1_d;
  logic [PW-1:0]   sum_q, sum_d, cry_q, cry_d, p_q, p_d;

  logic            w_mode;
  logic [W*W-1:0]  w_pp;
  logic [PW-1:0]   w_row, w_t, w_sum, w_cry;
  logic            w_rdy1, w_rdy2, w_rdy3;

  // Row i of the partial-product matrix lives at pp[i*W +: W].
  always_comb begin : pp_gen
    w_mode = SIGNED_EN && is_signed;
    w_pp   = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        w_pp[i*W+j] = a[j] & b[i];
        if (w_mode && (((i < W-1) && (j == W-1)) || ((i == W-1) && (j < W-1))))
          w_pp[i*W+j] = ~w_pp[i*W+j];
      end
    end
  end

  // Array-order 3:2 reduction: each row (plus the Baugh-Wooley constant row)
  // is folded into a running sum/carry pair, leaving two bits per column.
  always_comb begin : compress
    w_sum = '0;
    w_cry = '0;
    w_row = '0;
    w_t   = '0;
    for (int i = 0; i <= W; i++) begin
      if (i < W) begin
        w_row = PW'(pp_q[i*W +: W]) << i;
      end else begin
        w_row = '0;
        if (sgn1_q) begin
          w_row[W]    = 1'b1;
          w_row[PW-1] = 1'b1;
        end
      end
      w_t   = w_sum ^ w_cry ^ w_row;
      w_cry = ((w_sum & w_cry) | (w_sum & w_row) | (w_cry & w_row)) << 1;
      w_sum = w_t;
    end
  end

  always_comb begin : next_state
    w_rdy3 = !v3_q || out_ready;
    w_rdy2 = !v2_q || w_rdy3;
    w_rdy1 = !v1_q || w_rdy2;
    v1_d   = v1_q;
    pp_d   = pp_q;
    sgn1_d = sgn1_q;
    v2_d   = v2_q;
    sum_d  = sum_q;
    cry_d  = cry_q;
    v3_d   = v3_q;
    p_d    = p_q;
    if (w_rdy1) begin
      v1_d = in_valid;
      if (in_valid) begin
        pp_d   = w_pp;
        sgn1_d = w_mode;
      end
    end
    if (w_rdy2) begin
      v2_d = v1_q;
      if (v1_q) begin
        sum_d = w_sum;
        cry_d = w_cry;
      end
    end
    if (w_rdy3) begin
      v3_d = v2_q;
      if (v2_q) p_d = sum_q + cry_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      pp_q   <= '0;
      sgn1_q <= 1'b0;
      sum_q  <= '0;
      cry_q  <= '0;
      p_q    <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      pp_q   <= pp_d;
      sgn1_q <= sgn1_d;
      sum_q  <= sum_d;
      cry_q  <= cry_d;
      p_q    <= p_d;
    end
  end

  assign in_ready  = w_rdy1;
  assign out_valid = v3_q;
  assign p         = p_q;
  assign busy      = v1_q | v2_q | v3_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_mult_nxn.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_pipelined_mult_nxn: directed and streamed checks of the pipelined    |
// | multiplier at W=8, W=4 and W=16 (unsigned only). Revision: 1.0          |
// +------------------------------------------------------------------------+
module tb_pipelined_mult_nxn;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv8, ir8, s8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        iv4, ir4, s4, ov4, or4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        iv16, ir16, s16, ov16, or16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  pipelined_mult_nxn #(.W(8), .SIGNED_EN(1'b1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .p(p8), .busy(busy8));
  pipelined_mult_nxn #(.W(4), .SIGNED_EN(1'b1)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .is_signed(s4), .out_valid(ov4), .out_ready(or4), .p(p4), .busy(busy4));
  pipelined_mult_nxn #(.W(16), .SIGNED_EN(1'b0)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .is_signed(s16), .out_valid(ov16), .out_ready(or16), .p(p16), .busy(busy16));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic s);
    logic signed [7:0] sx, sy;
    sx = s ? {{4{x[3]}}, x} : {4'b0, x};
    sy = s ? {{4{y[3]}}, y} : {4'b0, y};
    return 8'(sx * sy);
  endfunction

  // One isolated operation: measures edges from input transfer to out_valid.
  task automatic run_one(input logic [7:0] x, input logic [7:0] y, input logic s,
                         input logic [15:0] exp, input string tag);
    int n;
    a8 = x; b8 = y; s8 = s; iv8 = 1'b1; or8 = 1'b1;
    #1;
    chk({tag, " in_ready"}, 32'(ir8), 32'd1);
    tick();
    iv8 = 1'b0;
    n = 1;
    while (!ov8 && n < 10) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'd3);
    chk({tag, " p"}, 32'(p8), 32'(exp));
    tick();
  endtask

  logic [7:0]  opa [5] = '{8'd1, 8'd2, 8'd4, 8'd6, 8'd8};
  logic [7:0]  opb [5] = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd9};
  logic [15:0] opp [5] = '{16'd1, 16'd6, 16'd20, 16'd42, 16'd72};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, j, cyc, idx, got;
    logic acc;
    logic [7:0]  q4 [$];
    logic [31:0] q16 [$];
    logic [31:0] e32;

    rst = 1'b1;
    iv8 = 0; a8 = 0; b8 = 0; s8 = 0; or8 = 0;
    iv4 = 0; a4 = 0; b4 = 0; s4 = 0; or4 = 0;
    iv16 = 0; a16 = 0; b16 = 0; s16 = 0; or16 = 0;
    tick();
    tick();
    chk("reset out_valid", 32'(ov8), 32'd0);
    chk("reset p", 32'(p8), 32'd0);
    chk("reset busy", 32'(busy8), 32'd0);
    rst = 1'b0;
    #1;
    chk("reset in_ready", 32'(ir8), 32'd1);
    tick();

    run_one(8'd255, 8'd255, 1'b0, 16'hFE01, "u 255x255");
    run_one(8'd0,   8'd173, 1'b0, 16'h0000, "u 0x173");
    run_one(8'd1,   8'd200, 1'b0, 16'h00C8, "u 1x200");
    run_one(8'h80, 8'h80, 1'b1, 16'h4000, "s 80x80");
    run_one(8'hFF, 8'h01, 1'b1, 16'hFFFF, "s FFx01");
    run_one(8'h7F, 8'h80, 1'b1, 16'hC080, "s 7Fx80");
    run_one(8'hFF, 8'hFF, 1'b1, 16'h0001, "s FFxFF");

    // Mode bit must travel with each operand pair.
    or8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b0; iv8 = 1'b1;
    tick();
    s8 = 1'b1;
    tick();
    iv8 = 1'b0;
    tick();
    chk("mixed first valid", 32'(ov8), 32'd1);
    chk("mixed first p", 32'(p8), 32'hFE01);
    tick();
    chk("mixed second valid", 32'(ov8), 32'd1);
    chk("mixed second p", 32'(p8), 32'h0001);
    tick();
    chk("mixed drained", 32'(ov8), 32'd0);

    // Backpressure: five ops against a stalled consumer.
    or8 = 1'b0; s8 = 1'b0; k = 0;
    for (int c = 0; c < 6; c++) begin
      iv8 = (k < 5);
      if (k < 5) begin a8 = opa[k]; b8 = opb[k]; end
      #1;
      acc = iv8 && ir8;
      tick();
      if (acc) k++;
    end
    chk("bp accepted", 32'(k), 32'd3);
    chk("bp in_ready low", 32'(ir8), 32'd0);
    chk("bp out_valid", 32'(ov8), 32'd1);
    chk("bp p hold", 32'(p8), 32'd1);
    or8 = 1'b1; j = 0; cyc = 0;
    while (j < 5 && cyc < 20) begin
      iv8 = (k < 5);
      if (k < 5) begin a8 = opa[k]; b8 = opb[k]; end
      #1;
      acc = iv8 && ir8;
      if (ov8 && or8) begin
        chk($sformatf("bp out %0d", j), 32'(p8), 32'(opp[j]));
        j++;
      end
      tick();
      if (acc) k++;
      cyc++;
    end
    iv8 = 1'b0;
    chk("bp result count", 32'(j), 32'd5);
    chk("bp no duplicate", 32'(ov8), 32'd0);

    // Bubble collapse with the consumer stalled.
    or8 = 1'b0; a8 = 8'd3; b8 = 8'd3; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    tick();
    tick();
    a8 = 8'd5; b8 = 8'd5; iv8 = 1'b1;
    #1;
    chk("bubble in_ready", 32'(ir8), 32'd1);
    tick();
    iv8 = 1'b0;
    tick();
    chk("bubble first p", 32'(p8), 32'd9);
    chk("bubble in_ready after", 32'(ir8), 32'd1);
    or8 = 1'b1;
    tick();
    chk("bubble second valid", 32'(ov8), 32'd1);
    chk("bubble second p", 32'(p8), 32'd25);
    tick();

    // Asynchronous reset with three ops in flight.
    or8 = 1'b0; iv8 = 1'b1;
    a8 = 8'd2; b8 = 8'd2; tick();
    a8 = 8'd3; b8 = 8'd3; tick();
    a8 = 8'd4; b8 = 8'd4; tick();
    iv8 = 1'b0;
    chk("pre-rst busy", 32'(busy8), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst out_valid", 32'(ov8), 32'd0);
    chk("rst p", 32'(p8), 32'd0);
    chk("rst busy", 32'(busy8), 32'd0);
    #1 rst = 1'b0;
    or8 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rst no stale", 32'(ov8), 32'd0);
    end
    run_one(8'd7, 8'd9, 1'b0, 16'd63, "post rst");

    // W=4: every pair in both modes, random consumer stalls.
    idx = 0; got = 0; cyc = 0;
    while ((idx < 512 || q4.size() > 0) && cyc < 5000) begin
      iv4 = (idx < 512);
      a4 = idx[3:0]; b4 = idx[7:4]; s4 = idx[8];
      or4 = 1'($urandom_range(0, 1));
      #1;
      if (ov4 && or4) begin
        chk("w4 p", 32'(p4), 32'(q4.pop_front()));
        got++;
      end
      if (iv4 && ir4) begin
        q4.push_back(ref4(a4, b4, s4));
        idx++;
      end
      tick();
      cyc++;
    end
    iv4 = 1'b0;
    chk("w4 result count", 32'(got), 32'd512);

    // W=16 unsigned-only build: is_signed must have no effect.
    idx = 0; got = 0; cyc = 0;
    while ((idx < 10000 || q16.size() > 0) && cyc < 40000) begin
      if (!(iv16 && !ir16)) begin
        a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom_range(0, 1));
      end
      iv16 = (idx < 10000);
      or16 = 1'($urandom_range(0, 1));
      #1;
      if (ov16 && or16) begin
        chk("w16 p", p16, q16.pop_front());
        got++;
      end
      if (iv16 && ir16) begin
        e32 = {16'b0, a16} * {16'b0, b16};
        q16.push_back(e32);
        idx++;
      end
      tick();
      cyc++;
    end
    iv16 = 1'b0;
    chk("w16 result count", 32'(got), 32'd10000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
